// File: rtl/sram_mem_controller_pkg.sv
// Shared constants and state encoding for the 32-bit to 16-bit SRAM bridge.
package sram_mem_controller_pkg;

    localparam int REGISTER_FILE_LEN     = 32;
    localparam int SRAM_DATA_LEN         = 16;
    localparam int DEFAULT_SRAM_ADDR_LEN = 18;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_LO = 3'd1,
        ST_RD_HI = 3'd2,
        ST_WR_LO = 3'd3,
        ST_WR_HI = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    function automatic logic is_access(input state_t s);
        return (s == ST_RD_LO) || (s == ST_RD_HI) || (s == ST_WR_LO) || (s == ST_WR_HI);
    endfunction

endpackage

// File: rtl/sram_mem_controller_if.sv
// Pipeline-side request/response plus the SRAM pin bundle of the controller.
interface sram_mem_controller_if #(
    parameter int SRAM_ADDR_LEN = sram_mem_controller_pkg::DEFAULT_SRAM_ADDR_LEN
);
    logic                     rd_en;
    logic                     wr_en;
    logic [31:0]              addr_in;
    logic [31:0]              wdata;
    logic [31:0]              rdata;
    logic                     ready;
    logic                     freeze;
    logic [SRAM_ADDR_LEN-1:0] sram_addr;
    logic                     sram_we_n;
    logic [15:0]              sram_dq_o;
    logic                     sram_dq_oe;
    logic [15:0]              sram_dq_i;

    // Master is the pipeline plus the external SRAM; slave is the controller.
    modport master (
        output rd_en, wr_en, addr_in, wdata, sram_dq_i,
        input  rdata, ready, freeze, sram_addr, sram_we_n, sram_dq_o, sram_dq_oe
    );

    modport slave (
        input  rd_en, wr_en, addr_in, wdata, sram_dq_i,
        output rdata, ready, freeze, sram_addr, sram_we_n, sram_dq_o, sram_dq_oe
    );
endinterface

// File: rtl/sram_access_timer.sv
// Per-phase cycle counter; o_last marks the final cycle of each SRAM access phase.
module sram_access_timer #(
    parameter int ACCESS_CYCLES = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic i_run,
    output logic o_last
);
    localparam int CW = (ACCESS_CYCLES < 1) ? 1 : $clog2(ACCESS_CYCLES + 1);

    logic [CW-1:0] r_cnt;

    assign o_last = i_run && (r_cnt == CW'(ACCESS_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || !i_run || o_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end
endmodule

// File: rtl/sram_mem_controller.sv
// Multi-cycle bridge from the MEM stage to a 16-bit async SRAM; one word = two halfword accesses.
module sram_mem_controller
    import sram_mem_controller_pkg::*;
#(
    parameter int BASE_ADDR     = 1024,
    parameter int ACCESS_CYCLES = 3,
    parameter int SRAM_ADDR_LEN = DEFAULT_SRAM_ADDR_LEN
) (
    input  logic                  clk,
    input  logic                  rst,
    sram_mem_controller_if.slave  bus
);
    state_t                         r_state;
    state_t                         w_next;
    logic [SRAM_ADDR_LEN-1:0]       r_sram_addr;
    logic [REGISTER_FILE_LEN-1:0]   r_rdata;
    logic [REGISTER_FILE_LEN-1:0]   r_wdata;
    logic [31:0]                    w_offset;
    logic [SRAM_ADDR_LEN-2:0]       w_idx;
    logic                           w_run;
    logic                           w_last;
    logic                           w_req;
    logic                           w_ready;
    logic                           w_we_n;
    logic                           w_dq_oe;
    logic [SRAM_DATA_LEN-1:0]       w_dq_o;
    logic                           w_unused_offset;

    // Upper offset bits are dropped on purpose: out-of-range addresses alias.
    assign w_offset        = bus.addr_in - 32'(BASE_ADDR);
    assign w_idx           = w_offset[SRAM_ADDR_LEN:2];
    assign w_unused_offset = ^{w_offset[31:SRAM_ADDR_LEN+1], w_offset[1:0]};

    assign w_req = bus.rd_en | bus.wr_en;
    assign w_run = is_access(r_state);

    sram_access_timer #(
        .ACCESS_CYCLES (ACCESS_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .i_run  (w_run),
        .o_last (w_last)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.wr_en)      w_next = ST_WR_LO;
                else if (bus.rd_en) w_next = ST_RD_LO;
            end
            ST_RD_LO: if (w_last) w_next = ST_RD_HI;
            ST_RD_HI: if (w_last) w_next = ST_DONE;
            ST_WR_LO: if (w_last) w_next = ST_WR_HI;
            ST_WR_HI: if (w_last) w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // WE rises on the last cycle so address/data stay stable one cycle past the write strobe.
    always_comb begin
        w_we_n  = 1'b1;
        w_dq_oe = 1'b0;
        w_dq_o  = '0;
        w_ready = 1'b0;
        case (r_state)
            ST_IDLE: w_ready = ~w_req;
            ST_WR_LO: begin
                w_dq_oe = 1'b1;
                w_dq_o  = r_wdata[SRAM_DATA_LEN-1:0];
                w_we_n  = w_last;
            end
            ST_WR_HI: begin
                w_dq_oe = 1'b1;
                w_dq_o  = r_wdata[REGISTER_FILE_LEN-1:SRAM_DATA_LEN];
                w_we_n  = w_last;
            end
            ST_DONE: w_ready = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_rdata     <= '0;
            r_wdata     <= '0;
            r_sram_addr <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: begin
                    if (w_req)      r_sram_addr <= {w_idx, 1'b0};
                    if (bus.wr_en)  r_wdata     <= bus.wdata;
                end
                ST_RD_LO: begin
                    if (w_last) begin
                        r_rdata[SRAM_DATA_LEN-1:0] <= bus.sram_dq_i;
                        r_sram_addr[0]             <= 1'b1;
                    end
                end
                ST_RD_HI: begin
                    if (w_last) r_rdata[REGISTER_FILE_LEN-1:SRAM_DATA_LEN] <= bus.sram_dq_i;
                end
                ST_WR_LO: begin
                    if (w_last) r_sram_addr[0] <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.rdata      = r_rdata;
    assign bus.sram_addr  = r_sram_addr;
    assign bus.sram_we_n  = w_we_n;
    assign bus.sram_dq_o  = w_dq_o;
    assign bus.sram_dq_oe = w_dq_oe;
    assign bus.ready      = w_ready;
    assign bus.freeze     = w_req & ~w_ready;
endmodule
